// File: rtl/cdc_req_arbiter.sv
// Round-robin arbiter granting one local resource to N requesters that
// sit in a foreign clock domain and use four-phase req/ack handshakes.
module cdc_req_arbiter #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_async,
  input  logic         done,
  output logic [N-1:0] grant,
  output logic [N-1:0] ack,
  output logic         busy,
  output logic         err
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ACK
  } state_t;

  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0]                  req_s;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [N-1:0]    ack_q, ack_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  logic [N-1:0]    elig;
  logic            found;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   jj;
  int              j;

  // Nothing touches req_async before the first flop of each chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_async};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];
  assign elig  = req_s & ~ack_q;

  // First eligible line scanning from rr_q upward, wrapping at N.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < N; k++) begin
      j  = (int'(rr_q) + k) % N;
      jj = IW'(j);
      if (!found && elig[jj]) begin
        found = 1'b1;
        pick  = jj;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = ack_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    timer_d = timer_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        ack_d   = '0;
        if (found) begin
          state_d = GRANT;
          idx_d   = pick;
          grant_d = N'(1) << pick;
          rr_d    = (pick == IW'(N - 1)) ? '0 : pick + 1'b1;
          timer_d = '0;
        end
      end
      GRANT: begin
        // done wins over withdrawal and timeout in the same cycle.
        if (done) begin
          state_d = ACK;
          grant_d = '0;
          ack_d   = N'(1) << idx_q;
        end else if (!req_s[idx_q]) begin
          state_d = IDLE;
          grant_d = '0;
          err_d   = 1'b1;
        end else if (timer_q == TW'(TIMEOUT)) begin
          state_d = IDLE;
          grant_d = '0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ACK: begin
        if (!req_s[idx_q]) begin
          state_d = IDLE;
          ack_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        ack_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      idx_q   <= '0;
      rr_q    <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign ack   = ack_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_cdc_req_arbiter.sv
// Directed bench for cdc_req_arbiter: latency, fairness, pending,
// withdrawal, timeout, done priority and asynchronous reset.
module tb_cdc_req_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req_async;
  logic         done;
  logic [N-1:0] grant;
  logic [N-1:0] ack;
  logic         busy;
  logic         err;

  int total = 0;
  int bad   = 0;
  int sb[$];
  int gidx;

  cdc_req_arbiter #(
    .N(N),
    .SYNC_STAGES(2),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_async(req_async),
    .done(done),
    .grant(grant),
    .ack(ack),
    .busy(busy),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic grant_now(input string tag);
    int e;
    e = (sb.size() > 0) ? sb.pop_front() : 0;
    gidx = e;
    chk(tag, 32'(grant), 32'(1) << e);
  endtask

  task automatic wait_grant(input string tag, input int budget);
    int n;
    n = 0;
    while (grant == '0 && n < budget) begin
      tick(1);
      n++;
    end
    grant_now(tag);
  endtask

  task automatic serve(input string tag, input int idx);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    chk({tag, "_ack"}, 32'(ack), 32'(1) << idx);
    chk({tag, "_gnt0"}, 32'(grant), 0);
    req_async[idx] = 1'b0;
    tick(2);
    chk({tag, "_ackhold"}, 32'(ack), 32'(1) << idx);
    tick(1);
    chk({tag, "_ackfall"}, 32'(ack), 0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_async = '0;
    done      = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    req_async = '0;
    done      = 1'b0;
    tick(3);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    tick(1);

    // single request, exact latency
    req_async[2] = 1'b1;
    sb.push_back(2);
    tick(2);
    chk("lat_early", 32'(grant), 0);
    tick(1);
    grant_now("lat_grant");
    chk("lat_busy", 32'(busy), 1);
    serve("single", 2);
    chk("single_err", 32'(err), 0);
    tick(1);
    chk("single_idle", 32'(busy), 0);

    // round-robin fairness
    do_reset();
    req_async = 4'b1111;
    sb.push_back(0);
    sb.push_back(1);
    sb.push_back(2);
    sb.push_back(3);
    sb.push_back(0);
    sb.push_back(1);
    for (int r = 0; r < 6; r++) begin
      wait_grant("rr_grant", 12);
      serve("rr", gidx);
      req_async[gidx] = 1'b1;
    end
    chk("rr_err", 32'(err), 0);

    // pending while busy
    do_reset();
    req_async[1] = 1'b1;
    sb.push_back(1);
    wait_grant("pend_g1", 10);
    req_async[3] = 1'b1;
    done = 1'b1;
    tick(1);
    done = 1'b0;
    chk("pend_ack1", 32'(ack), 32'b0010);
    req_async[0] = 1'b1;
    tick(3);
    chk("pend_ackhold", 32'(ack), 32'b0010);
    req_async[1] = 1'b0;
    sb.push_back(3);
    sb.push_back(0);
    wait_grant("pend_g3", 10);
    serve("pend3", 3);
    wait_grant("pend_g0", 10);
    serve("pend0", 0);
    chk("pend_err", 32'(err), 0);

    // withdrawal without done
    do_reset();
    req_async[0] = 1'b1;
    sb.push_back(0);
    wait_grant("wd_grant", 10);
    req_async[0] = 1'b0;
    tick(2);
    chk("wd_hold", 32'(grant), 32'b0001);
    chk("wd_err0", 32'(err), 0);
    tick(1);
    chk("wd_gnt0", 32'(grant), 0);
    chk("wd_ack0", 32'(ack), 0);
    chk("wd_err1", 32'(err), 1);
    tick(5);
    chk("wd_sticky", 32'(err), 1);
    chk("wd_noack", 32'(ack), 0);
    chk("wd_busy", 32'(busy), 0);

    // timeout: grant high TIMEOUT+1 cycles
    do_reset();
    req_async[2] = 1'b1;
    sb.push_back(2);
    wait_grant("to_grant", 10);
    chk("to_err0", 32'(err), 0);
    n = 0;
    while (grant != '0 && n < 20) begin
      n++;
      tick(1);
    end
    chk("to_cycles", 32'(n), 5);
    chk("to_err1", 32'(err), 1);
    chk("to_noack", 32'(ack), 0);

    // done coincident with timer==TIMEOUT
    do_reset();
    req_async[2] = 1'b1;
    sb.push_back(2);
    wait_grant("dp_grant", 10);
    tick(4);
    chk("dp_hold", 32'(grant), 32'b0100);
    serve("dp", 2);
    chk("dp_err", 32'(err), 0);

    // asynchronous reset during ACK
    do_reset();
    req_async[2] = 1'b1;
    sb.push_back(2);
    wait_grant("ar_grant", 10);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    chk("ar_ack", 32'(ack), 32'b0100);
    req_async[3] = 1'b1;
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ack0", 32'(ack), 0);
    chk("ar_gnt0", 32'(grant), 0);
    chk("ar_busy0", 32'(busy), 0);
    tick(2);
    rst_n = 1'b1;
    sb.push_back(2);
    wait_grant("ar_rearb", 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
